// File: rtl/instr_stream_loader.sv
// instr_stream_loader: packs a WASM byte stream little-endian into 64-bit words and writes them to instruction memory.
module instr_stream_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic              s_byte_vld,
  output logic              s_byte_rdy,
  input  logic [7:0]        s_byte_data,
  input  logic              s_byte_last,
  output logic              o_wr_vld,
  input  logic              i_wr_rdy,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [63:0]       o_wr_data,
  output logic              o_write_finish,
  output logic              o_busy,
  output logic              o_overflow,
  output logic [ADDR_W:0]   o_word_count
);
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, DRAIN, FINISH} state_t;
  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W+1)'(DEPTH);
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_idx;
  logic [63:0]       r_pack;
  logic              r_last;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;
  logic              w_byte_hs;
  logic              w_full;
  assign s_byte_rdy     = (r_state == COLLECT) || (r_state == DRAIN);
  assign o_wr_vld       = r_state == WRITE;
  assign o_write_finish = r_state == FINISH;
  assign o_busy         = r_state != IDLE;
  assign o_wr_addr      = r_addr;
  assign o_wr_data      = r_pack;
  assign o_overflow     = r_overflow;
  assign o_word_count   = r_count;
  assign w_byte_hs      = s_byte_vld & s_byte_rdy;
  // true while the pending write is the last one memory can hold
  assign w_full         = (r_count + (ADDR_W+1)'(1)) == LP_DEPTH;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_idx      <= '0;
      r_pack     <= '0;
      r_last     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          r_state    <= COLLECT;
          r_addr     <= '0;
          r_idx      <= '0;
          r_pack     <= '0;
          r_last     <= 1'b0;
          r_count    <= '0;
          r_overflow <= 1'b0;
        end
        COLLECT: if (w_byte_hs) begin
          r_pack[{r_idx, 3'b000} +: 8] <= s_byte_data;
          r_idx <= r_idx + 3'd1;
          if (r_idx == 3'd7 || s_byte_last) begin
            r_state <= WRITE;
            r_last  <= s_byte_last;
          end
        end
        WRITE: if (i_wr_rdy) begin
          r_count <= r_count + (ADDR_W+1)'(1);
          // hold the address on the final slot so it never points past DEPTH-1
          r_addr  <= w_full ? r_addr : r_addr + ADDR_W'(1);
          r_pack  <= '0;
          r_idx   <= '0;
          r_state <= r_last ? FINISH : (w_full ? DRAIN : COLLECT);
          if (!r_last && w_full) r_overflow <= 1'b1;
        end
        DRAIN: if (w_byte_hs && s_byte_last) r_state <= FINISH;
        FINISH: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
